// File: rtl/llc_cache_ctrl.sv
// llc_cache_ctrl: write-back, write-allocate set-associative cache with true-LRU and line-granular memory handshake
module llc_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int SETS       = 16,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic                         resp_hit,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_wr,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W*LINE_WORDS-1:0] mem_wdata,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W = DATA_W * LINE_WORDS;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT, RESP} state_t;
  state_t state, state_nx;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  vway;
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, inv, vdirty, upd_en;
  logic [WAY_W-1:0]  hway, iway, lway, vsel, upd_way, upd_age;
  logic [LINE_W-1:0] fill_line;
  logic [DATA_W-1:0] hit_word;
  assign off      = addr_q[OFF_W-1:0];
  assign idx      = addr_q[OFF_W +: IDX_W];
  assign tag      = addr_q[ADDR_W-1 -: TAG_W];
  assign vsel     = inv ? iway : lway;
  assign vdirty   = valid_q[idx][vsel] && dirty_q[idx][vsel];
  assign hit_word = data_q[idx][hway][off*DATA_W +: DATA_W];
  assign upd_en   = (state == LOOKUP && hit) || (state == FILL_WAIT && mem_resp_valid);
  assign upd_way  = state == LOOKUP ? hway : vway;
  assign upd_age  = age_q[idx][upd_way];
  assign req_ready     = state == IDLE;
  assign resp_valid    = state == RESP;
  assign mem_req_valid = state == WB_REQ || state == FILL_REQ;
  assign mem_req_wr    = state == WB_REQ;
  assign mem_req_addr  = state == WB_REQ   ? {tag_q[idx][vway], idx, {OFF_W{1'b0}}} :
                         state == FILL_REQ ? {tag, idx, {OFF_W{1'b0}}} : '0;
  assign mem_wdata     = state == WB_REQ ? data_q[idx][vway] : '0;
  // Tag match across the set plus victim candidates (lowest invalid way, else the oldest way)
  always_comb begin
    hit  = 1'b0;
    inv  = 1'b0;
    hway = '0;
    iway = '0;
    lway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv  = 1'b1;
        iway = WAY_W'(w);
      end
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit  = 1'b1;
        hway = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) lway = WAY_W'(w);
    end
  end
  // Incoming fill line with a pending write merged into its word
  always_comb begin
    fill_line = mem_rdata;
    if (wr_q) fill_line[off*DATA_W +: DATA_W] = wdata_q;
  end
  // Next-state selection for the miss-handling sequence
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = req_valid ? LOOKUP : IDLE;
      LOOKUP:    state_nx = hit ? RESP : vdirty ? WB_REQ : FILL_REQ;
      WB_REQ:    state_nx = mem_req_ready ? FILL_REQ : WB_REQ;
      FILL_REQ:  state_nx = mem_req_ready ? FILL_WAIT : FILL_REQ;
      FILL_WAIT: state_nx = mem_resp_valid ? RESP : FILL_WAIT;
      default:   state_nx = IDLE;
    endcase
  end
  // Control state, request latch, per-way metadata, LRU ages, response and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vway       <= '0;
      resp_hit   <= 1'b0;
      resp_rdata <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == LOOKUP) begin
        resp_hit <= hit;
        vway     <= vsel;
        if (hit) begin
          resp_rdata <= wr_q ? wdata_q : hit_word;
          if (wr_q) dirty_q[idx][hway] <= 1'b1;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end else if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if (state == FILL_WAIT && mem_resp_valid) begin
        valid_q[idx][vway] <= 1'b1;
        dirty_q[idx][vway] <= wr_q;
        tag_q[idx][vway]   <= tag;
        resp_rdata         <= fill_line[off*DATA_W +: DATA_W];
      end
      if (upd_en)
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == upd_way) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < upd_age) age_q[idx][w] <= age_q[idx][w] + 1'b1;
    end
  end
  // Line storage is deliberately left out of reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && wr_q) data_q[idx][hway][off*DATA_W +: DATA_W] <= wdata_q;
    if (state == FILL_WAIT && mem_resp_valid) data_q[idx][vway] <= fill_line;
  end
endmodule

// File: tb/tb_llc_cache_ctrl.sv
// tb_llc_cache_ctrl: scoreboard bench with a recency-list cache model and a flat memory model
module tb_llc_cache_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid, resp_hit;
  logic [7:0]  resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  llc_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [31:0] addr; logic [63:0] data; } mreq_t;
  typedef struct packed { logic hit; logic [7:0] data; } resp_t;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, drive_cyc = 0, last_resp_cyc = 0, resp_cnt = 0;
  int mh = 0, mm = 0, wb_cnt = 0;
  bit mem_auto = 1'b1;
  logic [31:0] last_wb_addr;
  logic [63:0] last_wb_data;
  logic [7:0]  mem_w  [int unsigned];
  logic [7:0]  golden [int unsigned];
  logic [24:0] lru_q  [16][$];
  bit          dirty_m [int unsigned];
  mreq_t mexp [$];
  resp_t rexp [$];

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_word(logic [31:0] a);
    return 8'(a - 32'h30);
  endfunction
  function automatic logic [7:0] mword(logic [31:0] a);
    return mem_w.exists(a) ? mem_w[a] : init_word(a);
  endfunction
  function automatic logic [7:0] gword(logic [31:0] a);
    return golden.exists(a) ? golden[a] : mword(a);
  endfunction
  function automatic logic [63:0] mline(logic [31:0] la);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = mword(la + 32'(k));
    return r;
  endfunction
  function automatic logic [63:0] gline(logic [31:0] la);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = gword(la + 32'(k));
    return r;
  endfunction

  // model: each set is a recency list (front = most recent); a full set evicts its back entry
  task automatic issue_req(bit wr, logic [31:0] a, logic [7:0] d);
    logic [31:0] la;
    logic [31:0] ea;
    logic [24:0] t;
    logic [24:0] ev;
    int s, pos, n;
    bit h;
    mreq_t m;
    resp_t r;
    la = a & ~32'h7;
    s = int'(a[6:3]);
    t = a[31:7];
    h = 1'b0;
    pos = 0;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == t) begin h = 1'b1; pos = i; end
    if (h) begin
      lru_q[s].delete(pos);
      mh++;
    end else begin
      mm++;
      if (lru_q[s].size() == 4) begin
        ev = lru_q[s].pop_back();
        ea = {ev, 4'(s), 3'b000};
        if (dirty_m.exists(ea)) begin
          m.wr = 1'b1; m.addr = ea; m.data = gline(ea);
          mexp.push_back(m);
          dirty_m.delete(ea);
        end
      end
      m.wr = 1'b0; m.addr = la; m.data = 64'h0;
      mexp.push_back(m);
    end
    lru_q[s].push_front(t);
    if (wr) begin
      golden[a] = d;
      dirty_m[la] = 1'b1;
    end
    r.hit = h;
    r.data = wr ? d : gword(a);
    rexp.push_back(r);
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("req_ready_wait", 0, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    drive_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int st, n;
    st = resp_cnt;
    n = 0;
    while (resp_cnt == st && n < 300) begin @(posedge clk); #1; n++; end
    chk("resp_arrived", 64'(resp_cnt != st), 1);
  endtask

  task automatic do_req(bit wr, logic [31:0] a, logic [7:0] d);
    issue_req(wr, a, d);
    wait_resp();
  endtask

  task automatic wait_mem_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
    chk("mem_req_seen", mem_req_valid, 1);
  endtask

  task automatic model_reset();
    rexp.delete();
    mexp.delete();
    dirty_m.delete();
    for (int s = 0; s < 16; s++) lru_q[s].delete();
    golden.delete();
    foreach (mem_w[k]) golden[k] = mem_w[k];
    mh = 0;
    mm = 0;
  endtask

  // response monitor
  resp_t rmon;
  initial forever begin
    @(negedge clk);
    if (resp_valid) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      if (rexp.size() == 0) chk("resp_unexpected", 1, 0);
      else begin
        rmon = rexp.pop_front();
        chk("resp_hit", resp_hit, rmon.hit);
        chk("resp_rdata", resp_rdata, rmon.data);
      end
    end
  end

  // memory responder with random handshake and fill delays
  mreq_t mmon;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [63:0] r_data;
  int          r_dly;
  initial begin
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && reset && mem_req_valid) begin
        if (mexp.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          mmon = mexp.pop_front();
          chk("mem_req_wr", mem_req_wr, mmon.wr);
          chk("mem_req_addr", mem_req_addr, mmon.addr);
          if (mmon.wr) chk("mem_wb_data", mem_wdata, mmon.data);
        end
        r_wr = mem_req_wr; r_addr = mem_req_addr; r_data = mem_wdata;
        r_dly = $urandom_range(0, 2);
        repeat (r_dly) @(negedge clk);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (r_wr) begin
          for (int k = 0; k < 8; k++) mem_w[r_addr + 32'(k)] = r_data[k*8 +: 8];
          wb_cnt++;
          last_wb_addr = r_addr;
          last_wb_data = r_data;
        end else begin
          r_dly = $urandom_range(0, 3);
          repeat (r_dly) begin @(posedge clk); #1; end
          mem_rdata = mline(r_addr);
          mem_resp_valid = 1'b1;
          @(posedge clk); #1;
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  mreq_t me;
  logic [31:0] a0;
  int rc0;
  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    // cold miss then hits in the same line
    do_req(0, 32'h40, 0);
    chk("miss_cnt_cold", miss_cnt, 1);
    do_req(0, 32'h43, 0);
    chk("hit_latency", last_resp_cyc - drive_cyc, 2);
    chk("hit_cnt_first", hit_cnt, 1);
    do_req(1, 32'h41, 8'hAB);
    do_req(0, 32'h41, 0);
    // fill the set, then evict the dirty 0x40 line
    for (int k = 1; k <= 4; k++) begin
      do_req(0, 32'h40 + 32'(k) * 32'h80, 0);
      if (k == 3) chk("no_wb_yet", wb_cnt, 0);
    end
    chk("wb_count", wb_cnt, 1);
    chk("wb_addr", last_wb_addr, 32'h40);
    chk("wb_word1", last_wb_data[15:8], 8'hAB);
    // stall the fill request and check that it holds steady
    mem_auto = 1'b0;
    issue_req(0, 32'h1000, 0);
    wait_mem_req();
    me = mexp.pop_front();
    chk("stall_wr", mem_req_wr, me.wr);
    chk("stall_addr0", mem_req_addr, me.addr);
    a0 = mem_req_addr;
    repeat (5) begin
      @(negedge clk);
      chk("stall_addr", mem_req_addr, a0);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_req_ready", req_ready, 0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rdata = mline(32'h1000);
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    wait_resp();
    // stray fill pulse while idle
    rc0 = resp_cnt;
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_pulse_ready", req_ready, 1);
    chk("idle_pulse_memvalid", mem_req_valid, 0);
    chk("idle_pulse_resp", resp_cnt, rc0);
    // reset during FILL_WAIT
    @(posedge clk); #1;
    issue_req(0, 32'h2000, 0);
    wait_mem_req();
    me = mexp.pop_front();
    chk("fw_addr", mem_req_addr, me.addr);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_mem_req_valid", mem_req_valid, 0);
    chk("arst_mem_req_wr", mem_req_wr, 0);
    chk("arst_mem_req_addr", mem_req_addr, 0);
    chk("arst_hit_cnt", hit_cnt, 0);
    chk("arst_miss_cnt", miss_cnt, 0);
    model_reset();
    rc0 = resp_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_rdata = mline(32'h2000);
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_fill_ready", req_ready, 1);
    chk("late_fill_resp", resp_cnt, rc0);
    @(posedge clk); #1;
    mem_auto = 1'b1;
    do_req(0, 32'h2000, 0);
    chk("post_rst_miss_cnt", miss_cnt, 1);
    chk("post_rst_hit_cnt", hit_cnt, 0);
    // randomized traffic over 8 tags per set
    for (int i = 0; i < 300; i++)
      do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), 8'($urandom));
    chk("final_hit_cnt", hit_cnt, 64'(mh));
    chk("final_miss_cnt", miss_cnt, 64'(mm));
    chk("final_mexp_empty", mexp.size(), 0);
    chk("final_rexp_empty", rexp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
